de10_input_pio_capture: RTL and testbench



---
 rtl/de10_input_pio_capture_if.sv | 25 ++
 rtl/de10_input_pio_capture.sv | 86 ++++++++
 tb/tb_de10_input_pio_capture.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/de10_input_pio_capture_if.sv
// Avalon-MM slave bus for the input PIO: 2-bit word address, 32-bit data,
// zero-wait-state combinational reads.
interface de10_input_pio_capture_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/de10_input_pio_capture.sv
// Input PIO for DE10 keys/switches: 2-flop sync, per-bit debounce, sticky edge capture, masked level irq.
// Pin-to-DATA latency 2+DEBOUNCE_CYCLES clk, pin-to-capture one more; reads are combinational, no stalls.
module de10_input_pio_capture #(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               EDGE_TYPE       = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    de10_input_pio_capture_if.slave       avs,
    input  logic [WIDTH-1:0]              in_port,
    output logic                          irq
);
    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_stable_d;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_capture;
    logic [CW-1:0]    r_cnt [WIDTH];

    logic             w_wr;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic             w_unused_wdata;

    assign w_wr           = avs.chipselect & ~avs.write_n;
    assign w_clr          = (w_wr && avs.address == 2'd3) ? avs.writedata[WIDTH-1:0] : '0;
    assign w_unused_wdata = ^avs.writedata;

    always_comb begin
        w_edge = r_stable & ~r_stable_d;
        if (EDGE_TYPE == 1)
            w_edge = ~r_stable & r_stable_d;
        else if (EDGE_TYPE == 2)
            w_edge = r_stable ^ r_stable_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1        <= RESET_VALUE;
            r_sync2        <= RESET_VALUE;
            r_stable       <= RESET_VALUE;
            r_stable_d     <= RESET_VALUE;
            r_irq_mask     <= '0;
            r_edge_capture <= '0;
            for (int i = 0; i < WIDTH; i++)
                r_cnt[i] <= '0;
        end else begin
            r_sync1    <= in_port;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            // Counter saturates implicitly: it clears on the update edge, so it never wraps.
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
            if (w_wr && avs.address == 2'd2)
                r_irq_mask <= avs.writedata[WIDTH-1:0];
            // A new edge in the same cycle as its clear keeps the bit set.
            r_edge_capture <= (r_edge_capture & ~w_clr) | w_edge;
        end
    end

    always_comb begin
        avs.readdata = '0;
        case (avs.address)
            2'd0:    avs.readdata = 32'(r_stable);
            2'd2:    avs.readdata = 32'(r_irq_mask);
            2'd3:    avs.readdata = 32'(r_edge_capture);
            default: avs.readdata = '0;
        endcase
    end

    assign irq = |(r_edge_capture & r_irq_mask);
endmodule

// File: tb/tb_de10_input_pio_capture.sv
// Bench for the input PIO with WIDTH=4, DEBOUNCE_CYCLES=4, rising-edge capture, reset value 0.
// Expected values are queued as stimulus is applied and popped as the DUT is observed.
module tb_de10_input_pio_capture;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] in_port;
    logic       irq;

    int          vectors    = 0;
    int          miscompares = 0;
    logic [31:0] exp_q [$];
    logic [31:0] got;
    logic [31:0] e;

    always #5 clk = ~clk;

    de10_input_pio_capture_if bus ();

    de10_input_pio_capture #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (4),
        .EDGE_TYPE       (0),
        .RESET_VALUE     (4'h0)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .avs     (bus),
        .in_port (in_port),
        .irq     (irq)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        #1;
        d = bus.readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic test_reset;
        in_port        = 4'h0;
        bus.address    = 2'd0;
        bus.writedata  = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        reset          = 1'b1;
        tick(2);
        reset = 1'b0;
        for (int a = 0; a < 4; a++) exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], got);
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL reset_read addr%0d: got %h want %h", a, got, e);
            end
        end
        e = exp_q.pop_front();
        vectors++;
        if (32'(irq) !== e) begin
            miscompares++;
            $display("FAIL reset_irq: got %b want %0d", irq, e);
        end
    endtask

    task automatic test_debounce_rise;
        in_port = 4'h1;
        for (int k = 1; k <= 8; k++) begin
            exp_q.push_back((k >= 6) ? 32'h1 : 32'h0);
            exp_q.push_back((k >= 7) ? 32'h1 : 32'h0);
            exp_q.push_back(32'h0);
        end
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            rd(2'd0, got);
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL rise_data clk%0d: got %h want %h", k, got, e);
            end
            rd(2'd3, got);
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL rise_capture clk%0d: got %h want %h", k, got, e);
            end
            e = exp_q.pop_front();
            vectors++;
            if (32'(irq) !== e) begin
                miscompares++;
                $display("FAIL rise_irq_masked clk%0d: got %b want %0d", k, irq, e);
            end
        end
    endtask

    task automatic test_irq_mask;
        // Each step: write, then expect (read addr, value) and irq.
        logic [1:0]  wa [6] = '{2'd2, 2'd3, 2'd2, 2'd2, 2'd0, 2'd1};
        logic [31:0] wd [6] = '{32'h1, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'hF, 32'hFFFF_FFFF};
        logic [1:0]  ra [6] = '{2'd2, 2'd3, 2'd2, 2'd2, 2'd0, 2'd1};
        logic [31:0] rv [6] = '{32'h1, 32'h0, 32'hF, 32'h0, 32'h1, 32'h0};
        logic        iv [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int s = 0; s < 6; s++) begin
            exp_q.push_back(rv[s]);
            exp_q.push_back(32'(iv[s]));
            wr(wa[s], wd[s]);
            e = exp_q.pop_front();
            rd(ra[s], got);
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL regmap step%0d addr%0d: got %h want %h", s, ra[s], got, e);
            end
            e = exp_q.pop_front();
            vectors++;
            if (32'(irq) !== e) begin
                miscompares++;
                $display("FAIL regmap_irq step%0d: got %b want %0d", s, irq, e);
            end
        end
    endtask

    task automatic test_glitch;
        in_port = 4'h5;
        for (int k = 1; k <= 10; k++) begin
            exp_q.push_back(32'h1);
            exp_q.push_back(32'h0);
        end
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            if (k == 3) in_port = 4'h1;
            rd(2'd0, got);
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL glitch_data clk%0d: got %h want %h", k, got, e);
            end
            rd(2'd3, got);
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL glitch_capture clk%0d: got %h want %h", k, got, e);
            end
        end
    endtask

    task automatic test_set_wins;
        in_port = 4'h9;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'h9);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h0);
        tick(6);
        rd(2'd3, got);
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL setwins_pre_capture: got %h want %h", got, e);
        end
        wr(2'd3, 32'h8);
        rd(2'd3, got);
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL setwins_capture: got %h want %h", got, e);
        end
        rd(2'd0, got);
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL setwins_data: got %h want %h", got, e);
        end
        wr(2'd3, 32'h8);
        rd(2'd3, got);
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL setwins_clear: got %h want %h", got, e);
        end
        in_port = 4'h1;
        tick(10);
        rd(2'd0, got);
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL fall_data: got %h want %h", got, e);
        end
        rd(2'd3, got);
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL fall_no_capture: got %h want %h", got, e);
        end
    endtask

    task automatic test_reset_mid;
        wr(2'd2, 32'hF);
        in_port = 4'h3;
        tick(4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        for (int a = 0; a < 4; a++) exp_q.push_back(32'h0);
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], got);
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL midreset_read addr%0d: got %h want %h", a, got, e);
            end
        end
        for (int k = 1; k <= 7; k++) begin
            exp_q.push_back((k >= 6) ? 32'h3 : 32'h0);
            exp_q.push_back((k >= 7) ? 32'h3 : 32'h0);
            exp_q.push_back(32'h0);
        end
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            rd(2'd0, got);
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL midreset_data clk%0d: got %h want %h", k, got, e);
            end
            rd(2'd3, got);
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL midreset_capture clk%0d: got %h want %h", k, got, e);
            end
            e = exp_q.pop_front();
            vectors++;
            if (32'(irq) !== e) begin
                miscompares++;
                $display("FAIL midreset_irq clk%0d: got %b want %0d", k, irq, e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_debounce_rise();
        test_irq_mask();
        test_glitch();
        test_set_wins();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
